// File: rtl/chunked_add_sub.sv
// chunked_add_sub: multi-cycle adder/subtractor. It processes CHUNK bits per
// clock, LSB chunk first, and passes the carry from one chunk to the next.
// A result takes N = WIDTH/CHUNK cycles after the operands are accepted. The
// operands are accepted through a valid/ready handshake, and the result is
// held until the consumer takes it.
module chunked_add_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;      // B, already inverted for subtract
  logic               carry_q, carry_d;
  logic [KW-1:0]      k_q, k_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [CHUNK-1:0]   a_ch, b_ch;
  logic [CHUNK:0]     res;
  logic               msb_cin;
  int                 base;

  // One chunk of ripple addition; the MSB of the result is the chunk carry-out
  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  endfunction

  // Next-state logic: operand capture, per-chunk add, and the handshakes
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    k_d     = k_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    base    = int'(k_q) * CHUNK;
    a_ch    = a_q[base +: CHUNK];
    b_ch    = b_q[base +: CHUNK];
    res     = add_chunk(a_ch, b_ch, carry_q);
    // The carry into the top bit of the chunk is recovered from that bit's sum
    msb_cin = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ res[CHUNK-1];

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B ^ {WIDTH{sub}};
          carry_d = sub;
          k_d     = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d[base +: CHUNK] = res[CHUNK-1:0];
        carry_d = res[CHUNK];
        if (k_q == K_LAST) begin
          cout_d  = res[CHUNK];
          ovf_d   = msb_cin ^ res[CHUNK];
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers; reset clears them and aborts any operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand registers: they are only read after a capture, so they need no reset
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;
  assign Zero      = (sum_q == '0);

endmodule

// File: doc/chunked_add_sub.md
CHUNKED_ADD_SUB -- requirements
Module: chunked_add_sub

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter CHUNK, default 8: bits added per clock cycle. WIDTH SHALL be an integer multiple of CHUNK, and CHUNK SHALL be >= 1. N = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 A  input  WIDTH  first operand.
REQ-008 B  input  WIDTH  second operand.
REQ-009 sub  input  1  0 selects A+B; 1 selects A-B.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 Sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 Cout  output  1  carry out of the MSB. For subtract, 1 means no borrow (A >= B unsigned).
REQ-014 Ovf  output  1  two's-complement overflow.
REQ-015 Zero  output  1  Sum == 0.

Function
REQ-016 FSM states: IDLE, BUSY, DONE. in_ready SHALL be 1 only in IDLE. out_valid SHALL be 1 only in DONE.
REQ-017 IDLE: when in_valid is 1 on an edge, the block SHALL capture A, B XOR {WIDTH{sub}}, and carry = sub, clear the chunk counter, and go to BUSY.
REQ-018 BUSY: on each edge the block SHALL add chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK, LSB chunk first) plus the stored carry. It SHALL write the chunk of Sum, update the carry, and increment k.
REQ-019 After the edge that processes chunk N-1, the block SHALL enter DONE.
  - out_valid rises exactly N cycles after the accepting edge.
  - Total latency is N cycles.
  - N=1 (CHUNK=WIDTH) SHALL work.
REQ-020 Cout SHALL be the carry out of bit WIDTH-1.
REQ-021 Ovf SHALL be the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1. Both are captured on the last chunk.
REQ-022 Zero SHALL be derived from the complete Sum and be valid whenever out_valid is 1.
REQ-023 DONE: Sum, Cout, Ovf, and Zero SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 DONE with out_ready=1 on an edge: go to IDLE. in_ready SHALL be 1 in the next cycle, with no same-edge accept of new operands.
REQ-025 in_valid in BUSY or DONE SHALL be ignored; A, B, and sub are sampled only at the accepting edge.
REQ-026 Outside DONE, Sum and flag values are unspecified except after reset. Consumers SHALL qualify them with out_valid.

Reset
REQ-027 rst=1 on an edge SHALL force IDLE from any state and abort any operation in progress.
REQ-028 On that edge, out_valid, Sum, Cout, Ovf, the carry, and the counter SHALL all go to 0; Zero SHALL go to 1; in_ready SHALL be 1 from the next cycle.
REQ-029 rst SHALL take priority over in_valid and out_ready on the same edge.

Verification (WIDTH=32, CHUNK=8, N=4, out_ready=1 unless stated)
REQ-030 add 0xFFFFFFFF + 0x00000001 -> out_valid 4 cycles after accept; Sum=0x00000000, Cout=1, Ovf=0, Zero=1.
REQ-031 sub 0x00000005 - 0x00000007 -> Sum=0xFFFFFFFE, Cout=0, Ovf=0, Zero=0.
REQ-032 add 0x7FFFFFFF + 0x00000001 -> Sum=0x80000000, Cout=0, Ovf=1. sub 0x80000000 - 0x00000001 -> Sum=0x7FFFFFFF, Cout=1, Ovf=1.
REQ-033 Backpressure: hold out_ready=0 for 3 cycles in DONE and drive new in_valid with other operands.
  - Outputs SHALL be unchanged and in_ready=0 throughout.
  - After the out_ready handshake, in_ready=1 one cycle later.
  - The next accepted operation SHALL give the correct result.
REQ-034 Assert rst after 2 BUSY edges -> next cycle IDLE, out_valid=0, Sum=0, Zero=1, in_ready=1. A new add 3+4 SHALL then give Sum=7.
REQ-035 Re-run REQ-030 and REQ-032 with CHUNK=32 (N=1) and CHUNK=1 (N=32); latency SHALL equal N.
